// File: rtl/blast_map_writer.sv
// Bomb blast walker: clears the bomb cell and then walks each arm of the blast cross.
// Bricks are cleared and every blasted cell is reported. Walls and other bombs stop an arm.
module blast_map_writer #(
    parameter  int NUM_ROW    = 11,
    parameter  int NUM_COL    = 19,
    parameter  int MAX_RADIUS = 7,
    localparam int ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL),
    localparam int RAD_W      = $clog2(MAX_RADIUS+1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_bomb_row,
    input  logic [4:0]            i_bomb_col,
    input  logic [RAD_W-1:0]      i_radius,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_map_addr,
    output logic                  o_map_re,
    output logic                  o_map_we,
    output logic [1:0]            o_map_wdata,
    input  logic [1:0]            i_map_rdata,
    output logic                  o_blast_valid,
    output logic [ADDR_WIDTH-1:0] o_blast_addr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CENTER = 3'd1,
        S_DIR    = 3'd2,
        S_READ   = 3'd3,
        S_EVAL   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_row;
    logic [4:0]              r_col;
    logic [RAD_W-1:0]        r_rad;
    logic [RAD_W-1:0]        r_k;
    logic [RAD_W-1:0]        w_k_nxt;
    logic [1:0]              r_dir;
    logic [1:0]              w_dir_nxt;

    logic signed [9:0]       w_k_s;
    logic signed [9:0]       w_trow;
    logic signed [9:0]       w_tcol;
    logic signed [9:0]       w_nrow;
    logic signed [9:0]       w_ncol;
    logic                    w_t_inb;
    logic                    w_n_inb;
    logic                    w_start_oob;
    logic [ADDR_WIDTH-1:0]   w_taddr;
    logic [ADDR_WIDTH-1:0]   w_bomb_addr;
    logic [RAD_W-1:0]        w_rad_clamped;

    // Targets are formed in signed 10-bit arithmetic so stepping off the top or left edge goes negative.
    function automatic logic signed [9:0] step_row(input logic [3:0] row, input logic [1:0] dir,
                                                   input logic signed [9:0] k);
        logic signed [9:0] base;
        base = $signed({6'b0, row});
        case (dir)
            D_UP:    return base - k;
            D_DOWN:  return base + k;
            default: return base;
        endcase
    endfunction

    function automatic logic signed [9:0] step_col(input logic [4:0] col, input logic [1:0] dir,
                                                   input logic signed [9:0] k);
        logic signed [9:0] base;
        base = $signed({5'b0, col});
        case (dir)
            D_LEFT:  return base - k;
            D_RIGHT: return base + k;
            default: return base;
        endcase
    endfunction

    function automatic logic in_bounds(input logic signed [9:0] row, input logic signed [9:0] col);
        return (row >= 10'sd0) && (row < $signed(10'(NUM_ROW))) &&
               (col >= 10'sd0) && (col < $signed(10'(NUM_COL)));
    endfunction

    assign w_k_s         = $signed({{(10-RAD_W){1'b0}}, r_k});
    assign w_trow        = step_row(r_row, r_dir, w_k_s);
    assign w_tcol        = step_col(r_col, r_dir, w_k_s);
    assign w_nrow        = step_row(r_row, r_dir, w_k_s + 10'sd1);
    assign w_ncol        = step_col(r_col, r_dir, w_k_s + 10'sd1);
    assign w_t_inb       = in_bounds(w_trow, w_tcol);
    assign w_n_inb       = in_bounds(w_nrow, w_ncol);
    assign w_taddr       = ADDR_WIDTH'(int'(w_trow) * NUM_COL + int'(w_tcol));
    assign w_bomb_addr   = ADDR_WIDTH'(int'(r_row) * NUM_COL + int'(r_col));
    assign w_start_oob   = (int'(i_bomb_row) >= NUM_ROW) || (int'(i_bomb_col) >= NUM_COL);
    assign w_rad_clamped = (int'(i_radius) > MAX_RADIUS) ? RAD_W'(MAX_RADIUS) : i_radius;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_dir   <= D_UP;
            r_k     <= RAD_W'(1);
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_rad <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_row <= i_bomb_row;
            r_col <= i_bomb_col;
            r_rad <= w_rad_clamped;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_dir_nxt   = D_UP;
                    w_k_nxt     = RAD_W'(1);
                    w_state_nxt = w_start_oob ? S_DONE : S_CENTER;
                end
            end
            S_CENTER: w_state_nxt = S_DIR;
            S_DIR: begin
                if (r_rad == '0 || !w_t_inb) begin
                    w_dir_nxt   = r_dir + 2'd1;
                    w_state_nxt = (r_dir == D_RIGHT) ? S_DONE : S_DIR;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: w_state_nxt = S_EVAL;
            S_EVAL: begin
                if (i_map_rdata == 2'b00 && r_k < r_rad && w_n_inb) begin
                    w_k_nxt     = r_k + 1'b1;
                    w_state_nxt = S_READ;
                end else begin
                    w_k_nxt     = RAD_W'(1);
                    w_dir_nxt   = r_dir + 2'd1;
                    w_state_nxt = (r_dir == D_RIGHT) ? S_DONE : S_DIR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_map_wdata = 2'b00;

    // Only the EVAL strobes depend on read data; everything else decodes from registered state.
    always_comb begin
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_map_addr    = '0;
        o_map_re      = 1'b0;
        o_map_we      = 1'b0;
        o_blast_valid = 1'b0;
        o_blast_addr  = '0;
        case (r_state)
            S_CENTER: begin
                o_busy        = 1'b1;
                o_map_we      = 1'b1;
                o_map_addr    = w_bomb_addr;
                o_blast_valid = 1'b1;
                o_blast_addr  = w_bomb_addr;
            end
            S_DIR: o_busy = 1'b1;
            S_READ: begin
                o_busy     = 1'b1;
                o_map_re   = 1'b1;
                o_map_addr = w_taddr;
            end
            S_EVAL: begin
                o_busy       = 1'b1;
                o_map_addr   = w_taddr;
                o_blast_addr = w_taddr;
                if (i_map_rdata == 2'b00) begin
                    o_blast_valid = 1'b1;
                end else if (i_map_rdata == 2'b10) begin
                    o_map_we      = 1'b1;
                    o_blast_valid = 1'b1;
                end
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_blast_map_writer.sv
// Bench for blast_map_writer: a map memory model, table vectors from the test plan,
// an async reset sequence and randomized blasts against a cross-walking reference model.
module tb_blast_map_writer;
    localparam int NR    = 11;
    localparam int NC    = 19;
    localparam int NCELL = NR * NC;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    brow;
    logic [4:0]    bcol;
    logic [2:0]    rad;
    logic          busy, done, map_re, map_we, blast_valid;
    logic [AW-1:0] map_addr, blast_addr;
    logic [1:0]    map_wdata, map_rdata;

    blast_map_writer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_bomb_row(brow), .i_bomb_col(bcol), .i_radius(rad),
        .o_busy(busy), .o_done(done), .o_map_addr(map_addr),
        .o_map_re(map_re), .o_map_we(map_we), .o_map_wdata(map_wdata),
        .i_map_rdata(map_rdata), .o_blast_valid(blast_valid), .o_blast_addr(blast_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row; int col; int rad; int brick; int wall; int hold;
        int done_cyc; int nb; int blast[10]; int nw; int wr[2];
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [1:0] mem [NCELL];
    logic [1:0] ref_map [NCELL];
    int act_blast[$], act_wr[$], exp_blast[$], exp_wr[$];
    int act_done, exp_done;
    int bad_busy, bad_strobe, bad_wdata, bad_idle;
    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int outs_or();
        return int'({busy, done, map_re, map_we, blast_valid, map_addr, blast_addr, map_wdata});
    endfunction

    // One clock: wait past the edge, then let the memory model respond to this cycle's strobes.
    task automatic step_cycle();
        @(posedge clk);
        #1;
        if (map_we) mem[map_addr] = 2'b00;
        if (map_re) map_rdata = mem[map_addr];
    endtask

    // Reference: walk each arm with plain arithmetic on a copy of the map.
    task automatic model_run(input int br, input int bc, input int rd);
        int cyc, tr, tc, a, r;
        int dr[4];
        int dc[4];
        dr = '{-1, 1, 0, 0};
        dc = '{0, 0, -1, 1};
        exp_blast.delete();
        exp_wr.delete();
        if (br >= NR || bc >= NC) begin
            exp_done = 1;
            return;
        end
        r = (rd > 7) ? 7 : rd;
        a = br * NC + bc;
        exp_blast.push_back(a);
        exp_wr.push_back(a);
        ref_map[a] = 2'b00;
        cyc = 1;
        for (int d = 0; d < 4; d++) begin
            cyc++;
            for (int k = 1; k <= r; k++) begin
                tr = br + dr[d] * k;
                tc = bc + dc[d] * k;
                if (tr < 0 || tr >= NR || tc < 0 || tc >= NC) break;
                cyc += 2;
                a = tr * NC + tc;
                if (ref_map[a] == 2'b00) begin
                    exp_blast.push_back(a);
                end else if (ref_map[a] == 2'b10) begin
                    exp_blast.push_back(a);
                    exp_wr.push_back(a);
                    ref_map[a] = 2'b00;
                    break;
                end else begin
                    break;
                end
            end
        end
        exp_done = cyc + 1;
    endtask

    task automatic run_dut(input int br, input int bc, input int rd, input int hold);
        brow = br[3:0];
        bcol = bc[4:0];
        rad  = rd[2:0];
        start = 1'b1;
        act_blast.delete();
        act_wr.delete();
        act_done = 0; bad_busy = 0; bad_strobe = 0; bad_wdata = 0; bad_idle = 0;
        for (int c = 1; c <= 200; c++) begin
            step_cycle();
            if (c >= hold) start = 1'b0;
            if (map_re && map_we) bad_strobe++;
            if (!busy) bad_busy++;
            if (blast_valid) act_blast.push_back(int'(blast_addr));
            if (map_we) begin
                act_wr.push_back(int'(map_addr));
                if (map_wdata != 2'b00) bad_wdata++;
            end
            if (done) begin
                act_done = c;
                break;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            if (busy || done || blast_valid || map_re || map_we) bad_idle++;
        end
    endtask

    task automatic compare_run(input string tag);
        int nmis;
        chk({tag, "_done_cycle"}, act_done, exp_done);
        chk({tag, "_nblast"}, act_blast.size(), exp_blast.size());
        for (int i = 0; i < act_blast.size() && i < exp_blast.size(); i++)
            chk($sformatf("%s_blast%0d", tag, i), act_blast[i], exp_blast[i]);
        chk({tag, "_nwrite"}, act_wr.size(), exp_wr.size());
        for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), act_wr[i], exp_wr[i]);
        chk({tag, "_re_we_overlap"}, bad_strobe, 0);
        chk({tag, "_busy_gap"}, bad_busy, 0);
        chk({tag, "_wdata"}, bad_wdata, 0);
        chk({tag, "_idle_after"}, bad_idle, 0);
        nmis = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== ref_map[i]) nmis++;
        chk({tag, "_final_map"}, nmis, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        for (int i = 0; i < NCELL; i++) mem[i] = 2'b00;
        if (v.brick >= 0) mem[v.brick] = 2'b10;
        if (v.wall >= 0) mem[v.wall] = 2'b01;
        for (int i = 0; i < NCELL; i++) ref_map[i] = mem[i];
        model_run(v.row, v.col, v.rad);
        exp_done = v.done_cyc;
        exp_blast.delete();
        exp_wr.delete();
        for (int i = 0; i < v.nb; i++) exp_blast.push_back(v.blast[i]);
        for (int i = 0; i < v.nw; i++) exp_wr.push_back(v.wr[i]);
        run_dut(v.row, v.col, v.rad, v.hold);
        compare_run(tag);
    endtask

    initial begin
        int br, bc, rd, hold;
        tbl[0] = '{5, 9, 2, -1, -1, 1, 22, 9, '{104, 85, 66, 123, 142, 103, 102, 105, 106, 0}, 1, '{104, 0}};
        tbl[1] = '{5, 9, 2, 105, 85, 1, 18, 6, '{104, 123, 142, 103, 102, 105, 0, 0, 0, 0}, 2, '{104, 105}};
        tbl[2] = '{0, 0, 3, -1, -1, 1, 18, 7, '{0, 19, 38, 57, 1, 2, 3, 0, 0, 0}, 1, '{0, 0}};
        tbl[3] = '{5, 9, 0, -1, -1, 6, 6, 1, '{104, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, '{104, 0}};
        tbl[4] = '{11, 0, 3, -1, -1, 1, 1, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0}};
        tbl[5] = '{5, 9, 1, -1, -1, 1, 14, 5, '{104, 85, 123, 103, 105, 0, 0, 0, 0, 0}, 1, '{104, 0}};

        brow = '0; bcol = '0; rad = '0; map_rdata = 2'b00;
        for (int i = 0; i < NCELL; i++) mem[i] = 2'b00;

        #12;
        chk("reset_outs", outs_or(), 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pull reset in the middle of an EVAL cycle.
        brow = 4'd5; bcol = 5'd9; rad = 3'd2; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step_cycle();
            start = 1'b0;
        end
        chk("pre_rst_eval_blast", int'(blast_valid), 1);
        chk("pre_rst_eval_addr", int'(blast_addr), 85);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outs", outs_or(), 0);
        @(posedge clk);
        #1 chk("rst_hold_outs", outs_or(), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_idle", outs_or(), 0);
        run_vec(tbl[5], "after_rst");

        for (int v = 0; v < 6; v++) run_vec(tbl[v], $sformatf("vec%0d", v));

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NCELL; i++) mem[i] = 2'($urandom_range(0, 3));
            for (int i = 0; i < NCELL; i++) ref_map[i] = mem[i];
            br   = $urandom_range(0, 11);
            bc   = $urandom_range(0, 19);
            rd   = $urandom_range(0, 7);
            hold = $urandom_range(1, 3);
            model_run(br, bc, rd);
            run_dut(br, bc, rd, hold);
            compare_run($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blast_map_writer.md
# blast_map_writer

Write-side companion to the obstacle checker on the shared map memory. When a bomb detonates, it walks the blast cross outward from the bomb cell, reading the map and clearing destructible bricks. It reports every blasted cell for the explosion renderer. It owns the map write port and one read request per cycle; arbitration against the obstacle checker's read address happens outside this block.

## Interface
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- MAX_RADIUS, 7, largest accepted blast radius in cells
- ADDR_WIDTH (local), $clog2(NUM_ROW*NUM_COL), map address width
- RAD_W (local), $clog2(MAX_RADIUS+1), radius width
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous assert, active-low
- start  in  1  detonation request, sampled only in IDLE
- bomb_row  in  4  bomb cell row
- bomb_col  in  5  bomb cell column
- radius  in  RAD_W  blast reach in cells per direction
- busy  out  1  high from CENTER through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- map_addr  out  ADDR_WIDTH  address for read or write, row*NUM_COL+col
- map_re  out  1  read strobe
- map_we  out  1  write strobe; map_wdata is written at map_addr
- map_wdata  out  2  always 2'b00 when map_we=1
- map_rdata  in  2  read data, valid the cycle after map_re
- blast_valid  out  1  one-cycle pulse per blasted cell
- blast_addr  out  ADDR_WIDTH  address of blasted cell, valid with blast_valid

## Operation
- Cell codes:
  - 00 free
  - 01 solid wall
  - 10 brick (destructible)
  - 11 bomb (blocking, not cleared, no chain reaction)
- States: IDLE, CENTER, DIR, READ, EVAL, DONE.
- IDLE, start=1:
  - Latch bomb_row, bomb_col, and radius, clamping radius to MAX_RADIUS.
  - Set dir=up, step k=1, and go to CENTER.
  - If bomb_row>=NUM_ROW or bomb_col>=NUM_COL, go to DONE directly with no memory access.
- CENTER: map_we=1, map_addr=bomb cell, blast_valid=1, blast_addr=bomb cell. Next state is DIR.
- DIR: no memory access.
  - If radius=0 or the step-1 target is out of bounds, advance dir in the order up, down, left, right. After right, go to DONE; otherwise stay in DIR.
  - Otherwise go to READ.
- READ: map_re=1, map_addr=target(dir,k). Next state is EVAL.
- EVAL, based on map_rdata:
  - 00: blast_valid=1, blast_addr=target. If k<radius and target(k+1) is in bounds, set k=k+1 and go to READ; else end the direction.
  - 10: map_we=1, map_addr=target, map_wdata=00, blast_valid=1. End the direction.
  - 01 or 11: no blast. End the direction.
  - Ending a direction resets k=1, advances dir, and goes to DIR; after right it goes to DONE.
- Targets:
  - up: (row-k, col)
  - down: (row+k, col)
  - left: (row, col-k)
  - right: (row, col+k)
  - Out of bounds means row<0, row>=NUM_ROW, col<0, or col>=NUM_COL. Compute in signed, widened arithmetic.
- DONE: done=1. Next state is IDLE.
- start outside IDLE is ignored, including start in the DONE cycle.

## Timing
- Reset (rst=0): state=IDLE immediately, all outputs 0. This holds even mid-blast; partial writes already made stay in memory.
- Strobes and addresses are registered outputs of the current state. There are no combinational paths from map_rdata to any output except through EVAL decode (map_we, blast_valid).
- Cycle counts: start sampled at edge 0, CENTER in cycle 1.
  - Each direction costs 1 DIR cycle plus 2 cycles per cell read.
  - DONE follows the last right-direction cycle.
- radius=0: CENTER cycle 1, DIR cycles 2–5, DONE cycle 6.
- At most one of map_re/map_we is high per cycle.

## Test plan
- Empty map, bomb (5,9), radius 2:
  - blast_addr sequence 104, 85, 66, 123, 142, 103, 102, 105, 106.
  - One write (104).
  - done in cycle 22.
- Brick at 105, wall at 85, bomb (5,9), radius 2:
  - Writes to 104 and 105 only.
  - No blast at 85; up ends after one read.
  - Right stops at 105.
- Bomb (0,0), radius 3, empty map:
  - up and left issue no map_re.
  - Blasts 0, 19, 38, 57, 1, 2, 3.
- radius=0 and a second start asserted while busy:
  - Only cell blasted/written is the bomb address.
  - done in cycle 6.
  - Second start produces no new run.
- Bomb (11,0), out of range:
  - No map_re/map_we.
  - done in cycle 1.
- rst driven low during an EVAL cycle:
  - All outputs 0 asynchronously.
  - After release, a new start at (5,9) radius 1 completes normally in 14 cycles.
